// File: rtl/johnson_decoder_if.sv
// Bus between a Johnson code source and the johnson_decoder.
// The master drives the sample strobe and code; the slave (decoder) returns
// the decoded count and the sequence status.
interface johnson_decoder_if #(
    parameter int N  = 12,
    parameter int CW = $clog2(2 * N)
);
    logic          en;
    logic [N-1:0]  q_in;
    logic          valid;
    logic [CW-1:0] count;
    logic          illegal;
    logic          seq_err;
    logic          locked;
    logic [7:0]    err_cnt;

    modport master (
        output en, q_in,
        input  valid, count, illegal, seq_err, locked, err_cnt
    );

    modport slave (
        input  en, q_in,
        output valid, count, illegal, seq_err, locked, err_cnt
    );
endinterface

// File: rtl/johnson_decoder.sv
// Johnson (twisted-ring) code receiver.
// Decodes an N-bit Johnson code to a binary count 0..2N-1. It also checks
// that each legal sample is the successor of the previous legal one, tracks
// lock, and keeps a saturating error count. All outputs are registered, so a
// sample taken on one edge is reported on the next edge.
module johnson_decoder #(
    parameter int N        = 12,
    parameter int LOCK_LEN = 4
) (
    input logic               clk,
    input logic               reset,
    johnson_decoder_if.slave  bus
);
    localparam int CW = $clog2(2 * N);
    localparam int RW = 4;  // holds LOCK_LEN up to 15

    localparam logic [CW-1:0] LAST_CNT = CW'(2 * N - 1);
    localparam logic [RW-1:0] LOCK_RUN = RW'(LOCK_LEN);

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKING,
        LOCKED
    } state_t;

    // Johnson code for count k.
    // For k <= N, the low k bits are ones.
    // For k > N, the low k-N bits are zeros and the rest are ones.
    function automatic logic [N-1:0] code_of(input int k);
        logic [N-1:0] code;
        for (int i = 0; i < N; i++) begin
            if (k <= N) code[i] = (i < k);
            else        code[i] = (i >= k - N);
        end
        return code;
    endfunction

    // Registered state
    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;  // also the previous legal sample
    logic [RW-1:0] run_q, run_d;
    logic          have_prev_q, have_prev_d;
    logic [7:0]    err_q, err_d;
    logic          valid_q, valid_d;
    logic          illegal_q, illegal_d;
    logic          seq_err_q, seq_err_d;

    // Combinational decode
    logic          dec_legal;
    logic [CW-1:0] dec_cnt;
    logic [CW-1:0] succ_cnt;
    logic [RW-1:0] run_inc;
    logic          err_event;

    // Decode the incoming code by matching it against every legal pattern.
    always_comb begin
        dec_legal = 1'b0;
        dec_cnt   = '0;
        for (int k = 0; k < 2 * N; k++) begin
            if (bus.q_in == code_of(k)) begin
                dec_legal = 1'b1;
                dec_cnt   = CW'(k);
            end
        end
    end

    // The expected next count wraps from 2N-1 back to 0.
    // The run length saturates at LOCK_LEN.
    assign succ_cnt = (count_q == LAST_CNT) ? '0 : count_q + CW'(1);
    assign run_inc  = (run_q >= LOCK_RUN) ? LOCK_RUN : run_q + RW'(1);

    // Next-state logic: sequence check, lock FSM, and error accounting.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        count_d     = count_q;
        run_d       = run_q;
        have_prev_d = have_prev_q;
        valid_d     = 1'b0;
        illegal_d   = 1'b0;
        seq_err_d   = 1'b0;
        err_event   = 1'b0;

        if (bus.en) begin
            valid_d = 1'b1;
            if (!dec_legal) begin
                illegal_d   = 1'b1;
                have_prev_d = 1'b0;
                run_d       = '0;
                state_d     = UNLOCKED;
                err_event   = 1'b1;
            end else if (!have_prev_q) begin
                count_d     = dec_cnt;
                have_prev_d = 1'b1;
                run_d       = RW'(1);
                state_d     = (LOCK_RUN == RW'(1)) ? LOCKED : LOCKING;
            end else if (dec_cnt == succ_cnt) begin
                count_d = dec_cnt;
                run_d   = run_inc;
                state_d = (run_inc == LOCK_RUN) ? LOCKED : LOCKING;
            end else begin
                // An out-of-order sample restarts the run but never locks.
                seq_err_d = 1'b1;
                count_d   = dec_cnt;
                run_d     = RW'(1);
                state_d   = LOCKING;
                err_event = 1'b1;
            end
        end

        err_d = (err_event && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    // State and output registers with a synchronous reset that overrides en.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples values from before the edge regardless of order.
        if (reset) begin
            state_q     <= UNLOCKED;
            count_q     <= '0;
            run_q       <= '0;
            have_prev_q <= 1'b0;
            err_q       <= '0;
            valid_q     <= 1'b0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            run_q       <= run_d;
            have_prev_q <= have_prev_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
            illegal_q   <= illegal_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign bus.valid   = valid_q;
    assign bus.count   = count_q;
    assign bus.illegal = illegal_q;
    assign bus.seq_err = seq_err_q;
    assign bus.locked  = (state_q == LOCKED);
    assign bus.err_cnt = err_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder.
// The reference model builds its code table by running a Johnson counter:
// it shifts left and feeds back the inverted MSB. It then tracks lock and
// errors with plain integers.
module tb_johnson_decoder;
    localparam int N  = 12;
    localparam int L  = 4;
    localparam int NS = 2 * N;

    logic clk;
    logic reset;

    johnson_decoder_if #(.N(N)) bus ();

    johnson_decoder #(.N(N), .LOCK_LEN(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference code table, index = count
    logic [N-1:0] tbl [NS];

    // Reference model state and expected outputs
    int m_count, m_run, m_err;
    bit m_have_prev, m_locked;
    bit e_valid, e_illegal, e_seq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [N-1:0] q);
        for (int k = 0; k < NS; k++)
            if (tbl[k] == q) return k;
        return -1;
    endfunction

    function automatic logic [N-1:0] rand_illegal();
        logic [N-1:0] q;
        do q = N'($urandom); while (decode(q) >= 0);
        return q;
    endfunction

    task automatic model(input bit r, input bit e, input logic [N-1:0] q);
        int d;
        e_valid   = 0;
        e_illegal = 0;
        e_seq     = 0;
        if (r) begin
            m_count = 0; m_run = 0; m_err = 0; m_have_prev = 0; m_locked = 0;
        end else if (e) begin
            e_valid = 1;
            d = decode(q);
            if (d < 0) begin
                e_illegal = 1; m_have_prev = 0; m_run = 0; m_locked = 0;
                if (m_err < 255) m_err++;
            end else if (!m_have_prev) begin
                m_count = d; m_have_prev = 1; m_run = 1; m_locked = (L == 1);
            end else if (d == (m_count + 1) % NS) begin
                m_count = d;
                if (m_run < L) m_run++;
                m_locked = (m_run == L);
            end else begin
                e_seq = 1; m_count = d; m_run = 1; m_locked = 0;
                if (m_err < 255) m_err++;
            end
        end
    endtask

    // Drive one cycle, advance the model, then compare every output.
    task automatic cycle(input bit r, input bit e, input logic [N-1:0] q, input string tag);
        reset    = r;
        bus.en   = e;
        bus.q_in = q;
        @(posedge clk);
        model(r, e, q);
        #1;
        chk({tag, ".valid"},   32'(bus.valid),   32'(e_valid));
        chk({tag, ".count"},   32'(bus.count),   32'(m_count));
        chk({tag, ".illegal"}, 32'(bus.illegal), 32'(e_illegal));
        chk({tag, ".seq_err"}, 32'(bus.seq_err), 32'(e_seq));
        chk({tag, ".locked"},  32'(bus.locked),  32'(m_locked));
        chk({tag, ".err_cnt"}, 32'(bus.err_cnt), 32'(m_err));
    endtask

    initial begin
        logic [N-1:0] q;
        int k, sel;

        q = '0;
        for (int i = 0; i < NS; i++) begin
            tbl[i] = q;
            q = {q[N-2:0], ~q[N-1]};
        end

        reset = 1'b1; bus.en = 1'b0; bus.q_in = '0;
        m_count = 0; m_run = 0; m_err = 0; m_have_prev = 0; m_locked = 0;

        // Reset state
        cycle(1, 0, '0, "reset0");
        cycle(1, 1, 12'h005, "reset1");

        // Lock from reset: codes 0..23, then wrap to 0
        for (int i = 0; i < NS; i++) begin
            cycle(0, 1, tbl[i], $sformatf("lock%0d", i));
            if (i == L - 2) chk("plan_not_locked_yet", 32'(bus.locked), 32'd0);
            if (i == L - 1) chk("plan_locked_4th", 32'(bus.locked), 32'd1);
        end
        chk("plan_c00_is_22", 32'(tbl[22]), 32'h00000c00);
        cycle(0, 1, 12'h000, "wrap");
        chk("plan_wrap_count", 32'(bus.count), 32'd0);
        chk("plan_wrap_locked", 32'(bus.locked), 32'd1);
        chk("plan_wrap_seq", 32'(bus.seq_err), 32'd0);

        // Illegal code, then relock
        cycle(0, 1, 12'h005, "illegal");
        chk("plan_illegal_hold", 32'(bus.count), 32'd0);
        chk("plan_illegal_err", 32'(bus.err_cnt), 32'd1);
        chk("plan_illegal_flag", 32'(bus.illegal), 32'd1);
        cycle(0, 1, 12'h007, "relock0");
        cycle(0, 1, 12'h00F, "relock1");
        cycle(0, 1, 12'h01F, "relock2");
        cycle(0, 1, 12'h03F, "relock3");
        chk("plan_relocked", 32'(bus.locked), 32'd1);

        // Advance to count 2 (code 003), then skip to 4
        for (int i = 7; i < NS + 3; i++)
            cycle(0, 1, tbl[i % NS], $sformatf("adv%0d", i));
        cycle(0, 1, 12'h00F, "skip");
        chk("plan_skip_seq", 32'(bus.seq_err), 32'd1);
        chk("plan_skip_count", 32'(bus.count), 32'd4);
        chk("plan_skip_err", 32'(bus.err_cnt), 32'd2);
        chk("plan_skip_unlock", 32'(bus.locked), 32'd0);
        cycle(0, 1, 12'h01F, "skip_r0");
        cycle(0, 1, 12'h03F, "skip_r1");
        cycle(0, 1, 12'h07F, "skip_r2");
        chk("plan_skip_relock", 32'(bus.locked), 32'd1);

        // Gaps of 5 idle cycles between successive codes
        for (int i = 8; i < 12; i++) begin
            for (int g = 0; g < 5; g++)
                cycle(0, 0, N'($urandom), $sformatf("gap%0d_%0d", i, g));
            cycle(0, 1, tbl[i], $sformatf("gapcode%0d", i));
        end

        // Reset on an en=1 cycle
        cycle(1, 1, tbl[12], "reset_en");
        chk("plan_reset_locked", 32'(bus.locked), 32'd0);
        chk("plan_reset_err", 32'(bus.err_cnt), 32'd0);

        // Randomised mix
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(99));
            if (sel < 8) q = rand_illegal();
            else if (sel < 18) q = tbl[m_count];
            else if (sel < 30) q = tbl[$urandom_range(NS - 1)];
            else q = tbl[(m_count + 1) % NS];
            cycle(($urandom_range(99) == 0), ($urandom_range(3) != 0), q,
                  $sformatf("rnd%0d", i));
        end

        // Saturation
        cycle(1, 0, '0, "sat_reset");
        for (int i = 0; i < 300; i++)
            cycle(0, 1, rand_illegal(), $sformatf("sat%0d", i));
        chk("plan_sat_err", 32'(bus.err_cnt), 32'd255);
        chk("plan_sat_illegal", 32'(bus.illegal), 32'd1);
        cycle(0, 0, '0, "sat_idle");
        chk("plan_sat_hold", 32'(bus.err_cnt), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
